// File: rtl/cpu_pkg.sv
// Shared core types: register-file widths and the write-back queue entry.
// Imported by the write-back queue and its youngest-match search.
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   reg_data_t;

  typedef struct packed {
    reg_addr_t waddr;
    reg_data_t wdata;
  } wb_entry_t;

endpackage

// File: rtl/wbq_match.sv
// Youngest-match search over age-ordered queue entries (index 0 oldest).
// Register 0 never hits.
module wbq_match
  import cpu_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = REG_AW,
  parameter int DATA_WIDTH = XLEN
) (
  input  wb_entry_t              ents [DEPTH],
  input  logic [DEPTH-1:0]       vld,
  input  logic [ADDR_WIDTH-1:0]  raddr,
  output logic                   hit,
  output logic [DATA_WIDTH-1:0]  data
);

  reg_addr_t key;

  assign key = reg_addr_t'(raddr);

  // later (younger) matches overwrite earlier ones
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (vld[j] && key != '0 && ents[j].waddr == key) begin
        hit  = 1'b1;
        data = DATA_WIDTH'(ents[j].wdata);
      end
    end
  end

endmodule

// File: rtl/reg_wb_queue.sv
// Register write-back queue: FIFO of pending writes draining into the RF.
// Pending-write bypass lookup is built only when WBQ_BYPASS_EN is defined.
module reg_wb_queue
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_AW,
  parameter int DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ADDR_WIDTH-1:0]       in_waddr,
  input  logic [DATA_WIDTH-1:0]       in_wdata,
  input  logic                        flush,
  input  logic                        rf_stall,
  output logic                        rf_wen,
  output logic [ADDR_WIDTH-1:0]       rf_waddr,
  output logic [DATA_WIDTH-1:0]       rf_wdata,
  input  logic [ADDR_WIDTH-1:0]       byp_raddr1,
  input  logic [ADDR_WIDTH-1:0]       byp_raddr2,
  output logic                        byp_hit1,
  output logic                        byp_hit2,
  output logic [DATA_WIDTH-1:0]       byp_data1,
  output logic [DATA_WIDTH-1:0]       byp_data2,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       mem [DEPTH];
  wb_entry_t       head_ent;
  wb_entry_t       new_ent;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   cnt;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  assign full     = cnt == CW'(DEPTH);
  assign empty    = cnt == '0;
  assign in_ready = !full;
  assign count    = cnt;

  // writes to r0 complete the handshake but allocate nothing
  assign push = in_valid && !full && !flush && (in_waddr != '0);
  assign rf_wen = !empty && !rf_stall && !flush;
  assign pop  = rf_wen;

  assign head_ent = mem[head];
  assign rf_waddr = empty ? '0 : ADDR_WIDTH'(head_ent.waddr);
  assign rf_wdata = empty ? '0 : DATA_WIDTH'(head_ent.wdata);

  assign new_ent = '{
    waddr: reg_addr_t'(in_waddr),
    wdata: reg_data_t'(in_wdata)
  };

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // payload storage is not reset; occupancy alone defines validity
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= new_ent;
  end

`ifdef WBQ_BYPASS_EN
  wb_entry_t        ord [DEPTH];
  logic [DEPTH-1:0] vld;

  for (genvar j = 0; j < DEPTH; j++) begin : g_age
    assign ord[j] = mem[head + PW'(j)];
    assign vld[j] = CW'(j) < cnt;
  end

  wbq_match #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_match1 (
    .ents  (ord),
    .vld   (vld),
    .raddr (byp_raddr1),
    .hit   (byp_hit1),
    .data  (byp_data1)
  );

  wbq_match #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_match2 (
    .ents  (ord),
    .vld   (vld),
    .raddr (byp_raddr2),
    .hit   (byp_hit2),
    .data  (byp_data2)
  );
`else
  logic [2*ADDR_WIDTH-1:0] byp_unused;

  assign byp_unused = {byp_raddr1, byp_raddr2};
  assign byp_hit1   = 1'b0;
  assign byp_hit2   = 1'b0;
  assign byp_data1  = '0;
  assign byp_data2  = '0;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Bench for reg_wb_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_reg_wb_queue;

  localparam int DEPTH = 4;
`ifdef WBQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_waddr = '0;
  logic [31:0] in_wdata = '0;
  logic        flush = 1'b0;
  logic        rf_stall = 1'b0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  byp_raddr1 = '0;
  logic [4:0]  byp_raddr2 = '0;
  logic        byp_hit1;
  logic        byp_hit2;
  logic [31:0] byp_data1;
  logic [31:0] byp_data2;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;
  ent_t mq[$];

  reg_wb_queue #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_waddr   (in_waddr),
    .in_wdata   (in_wdata),
    .flush      (flush),
    .rf_stall   (rf_stall),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .byp_raddr1 (byp_raddr1),
    .byp_raddr2 (byp_raddr2),
    .byp_hit1   (byp_hit1),
    .byp_hit2   (byp_hit2),
    .byp_data1  (byp_data1),
    .byp_data2  (byp_data2),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic set_in(input bit v, input int a, input int d,
                        input bit f, input bit s);
    @(negedge clk);
    in_valid = v;
    in_waddr = a[4:0];
    in_wdata = d;
    flush    = f;
    rf_stall = s;
    #1;
  endtask

  // advance one edge, applying the queue rules to the model
  task automatic tick();
    bit rdy;
    bit wen;
    rdy = mq.size() != DEPTH;
    wen = mq.size() != 0 && !rf_stall && !flush;
    if (flush) mq.delete();
    else begin
      if (wen) mq.delete(0);
      if (in_valid && rdy && in_waddr != 0)
        mq.push_back('{a: in_waddr, d: in_wdata});
    end
    @(posedge clk);
  endtask

  function automatic bit m_hit(input logic [4:0] a);
    m_hit = 1'b0;
    if (a == 0) return 1'b0;
    foreach (mq[i]) if (mq[i].a == a) m_hit = BYP;
  endfunction

  function automatic logic [31:0] m_data(input logic [4:0] a);
    m_data = '0;
    if (a == 0 || !BYP) return '0;
    foreach (mq[i]) if (mq[i].a == a) m_data = mq[i].d;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (rf_wen !== 1'b0) begin
      failures++; $display("FAIL reset_wen got=%0d exp=0", rf_wen);
    end
    checks++;
    if (count !== 3'd0) begin
      failures++; $display("FAIL reset_count got=%0d exp=0", count);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%0d exp=1", in_ready);
    end
    checks++;
    if (byp_hit1 !== 1'b0 || byp_hit2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_hit got=%0d%0d exp=00", byp_hit1, byp_hit2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    set_in(0, 0, 0, 0, 0);
    checks++;
    if (rf_wen !== 1'b0) begin
      failures++; $display("FAIL post_reset_wen got=%0d exp=0", rf_wen);
    end
    tick();
  endtask

  task automatic test_single();
    set_in(1, 3, 32'h11, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0);
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h11) begin
      failures++;
      $display("FAIL single_write got=%0d/%0d/%0h exp=1/3/11",
               rf_wen, rf_waddr, rf_wdata);
    end
    tick();
    set_in(0, 0, 0, 0, 0);
    checks++;
    if (count !== 3'd0 || rf_wen !== 1'b0) begin
      failures++;
      $display("FAIL single_drain got=%0d/%0d exp=0/0", count, rf_wen);
    end
  endtask

  task automatic test_full_drain();
    ent_t exp[4];
    for (int i = 0; i < 4; i++) begin
      exp[i].a = 5'(i + 1);
      exp[i].d = $urandom;
      set_in(1, int'(exp[i].a), int'(exp[i].d), 0, 1);
      tick();
    end
    set_in(1, 7, 32'hDEAD, 0, 1);
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_state got=%0d/%0d exp=4/0", count, in_ready);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0);
      checks++;
      if (rf_wen !== 1'b1 || rf_waddr !== exp[i].a ||
          rf_wdata !== exp[i].d) begin
        failures++;
        $display("FAIL drain_%0d got=%0d/%0d/%0h exp=1/%0d/%0h", i,
                 rf_wen, rf_waddr, rf_wdata, exp[i].a, exp[i].d);
      end
      tick();
    end
    set_in(0, 0, 0, 0, 0);
    checks++;
    if (count !== 3'd0 || rf_wen !== 1'b0) begin
      failures++;
      $display("FAIL drain_end got=%0d/%0d exp=0/0", count, rf_wen);
    end
  endtask

  task automatic test_r0();
    set_in(1, 0, 32'hFF, 0, 0);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL r0_ready got=%0d exp=1", in_ready);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0);
      checks++;
      if (count !== 3'd0 || rf_wen !== 1'b0) begin
        failures++;
        $display("FAIL r0_drop got=%0d/%0d exp=0/0", count, rf_wen);
      end
      tick();
    end
  endtask

  task automatic test_bypass();
    set_in(1, 5, 32'hA, 0, 1);
    tick();
    set_in(1, 5, 32'hB, 0, 1);
    tick();
    byp_raddr1 = 5'd5;
    byp_raddr2 = 5'd6;
    set_in(0, 0, 0, 0, 1);
    checks++;
    if (byp_hit1 !== BYP || byp_data1 !== (BYP ? 32'hB : 32'h0)) begin
      failures++;
      $display("FAIL byp_hit_r5 got=%0d/%0h exp=%0d/%0h", byp_hit1,
               byp_data1, BYP, BYP ? 32'hB : 32'h0);
    end
    checks++;
    if (byp_hit2 !== 1'b0 || byp_data2 !== 32'h0) begin
      failures++;
      $display("FAIL byp_miss_r6 got=%0d/%0h exp=0/0", byp_hit2, byp_data2);
    end
    byp_raddr2 = 5'd0;
    #1;
    checks++;
    if (byp_hit2 !== 1'b0) begin
      failures++; $display("FAIL byp_r0 got=%0d exp=0", byp_hit2);
    end
    tick();
    set_in(0, 0, 0, 1, 0);
    tick();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 10 + i, int'($urandom), 0, 1);
      tick();
    end
    set_in(1, 9, 32'h99, 1, 0);
    checks++;
    if (count !== 3'd3 || rf_wen !== 1'b0) begin
      failures++;
      $display("FAIL flush_cycle got=%0d/%0d exp=3/0", count, rf_wen);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 0);
      checks++;
      if (count !== 3'd0 || rf_wen !== 1'b0) begin
        failures++;
        $display("FAIL flush_after got=%0d/%0d exp=0/0", count, rf_wen);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    set_in(1, 12, 32'h1234, 0, 1);
    tick();
    set_in(1, 13, 32'h5678, 0, 1);
    tick();
    set_in(0, 0, 0, 0, 0);
    checks++;
    if (rf_wen !== 1'b1) begin
      failures++; $display("FAIL mid_pre_wen got=%0d exp=1", rf_wen);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rf_wen !== 1'b0 || count !== 3'd0) begin
      failures++;
      $display("FAIL mid_reset got=%0d/%0d exp=0/0", rf_wen, count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0);
      checks++;
      if (rf_wen !== 1'b0 || count !== 3'd0) begin
        failures++;
        $display("FAIL mid_after got=%0d/%0d exp=0/0", rf_wen, count);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [4:0]  ea;
    logic [31:0] ed;
    for (int n = 0; n < 400; n++) begin
      byp_raddr1 = 5'($urandom_range(0, 7));
      byp_raddr2 = 5'($urandom_range(0, 7));
      set_in(($urandom % 3) != 0, int'($urandom_range(0, 7)),
             int'($urandom), ($urandom % 16) == 0, ($urandom % 3) == 0);
      ea = mq.size() != 0 ? mq[0].a : 5'd0;
      ed = mq.size() != 0 ? mq[0].d : 32'd0;
      checks++;
      if (rf_wen !== (mq.size() != 0 && !rf_stall && !flush)) begin
        failures++; $display("FAIL rnd_wen n=%0d got=%0d", n, rf_wen);
      end
      checks++;
      if (rf_waddr !== ea || rf_wdata !== ed) begin
        failures++;
        $display("FAIL rnd_head n=%0d got=%0d/%0h exp=%0d/%0h",
                 n, rf_waddr, rf_wdata, ea, ed);
      end
      checks++;
      if (count !== 3'(mq.size()) || in_ready !== (mq.size() != DEPTH)) begin
        failures++;
        $display("FAIL rnd_count n=%0d got=%0d/%0d exp=%0d",
                 n, count, in_ready, mq.size());
      end
      checks++;
      if (byp_hit1 !== m_hit(byp_raddr1) ||
          byp_data1 !== m_data(byp_raddr1)) begin
        failures++;
        $display("FAIL rnd_byp1 n=%0d got=%0d/%0h exp=%0d/%0h", n,
                 byp_hit1, byp_data1, m_hit(byp_raddr1), m_data(byp_raddr1));
      end
      checks++;
      if (byp_hit2 !== m_hit(byp_raddr2) ||
          byp_data2 !== m_data(byp_raddr2)) begin
        failures++;
        $display("FAIL rnd_byp2 n=%0d got=%0d/%0h exp=%0d/%0h", n,
                 byp_hit2, byp_data2, m_hit(byp_raddr2), m_data(byp_raddr2));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_drain();
    test_r0();
    test_bypass();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_wb_queue.md
REG_WB_QUEUE -- requirements
Module: reg_wb_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register index width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries, power of two, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_waddr (input, ADDR_WIDTH) and in_wdata (input, DATA_WIDTH): the producer write-request handshake.
REQ-007 SHALL have port flush, input, 1 bit: synchronous discard of all queued entries.
REQ-008 SHALL have port rf_stall, input, 1 bit: the register-file write port is busy this cycle.
REQ-009 SHALL have ports rf_wen (output, 1), rf_waddr (output, ADDR_WIDTH) and rf_wdata (output, DATA_WIDTH): these drive the register-file write port.
REQ-010 SHALL have ports byp_raddr1 and byp_raddr2 (input, ADDR_WIDTH), byp_hit1 and byp_hit2 (output, 1), and byp_data1 and byp_data2 (output, DATA_WIDTH): the pending-write lookup.
REQ-011 SHALL have port count, output, clog2(DEPTH)+1 bits: the number of occupied entries.

Function
REQ-012 SHALL be a circular FIFO of {waddr, wdata} with head and tail pointers that wrap modulo DEPTH.
REQ-013 SHALL drive in_ready = (count != DEPTH) combinationally from registered state only; there is no combinational path from in_valid.
REQ-014 SHALL enqueue at the tail when in_valid && in_ready && !flush && in_waddr != 0.
REQ-015 SHALL accept and drop a write to register 0: the handshake completes, no entry is allocated and count is unchanged.
REQ-016 SHALL drive rf_wen = (count != 0) && !rf_stall, with rf_waddr and rf_wdata taken from the head entry; the head pops on the same edge that rf_wen is sampled high.
REQ-017 SHALL give a minimum latency of 1 cycle: a request accepted at edge N can appear on rf_wen in the cycle following edge N.
REQ-018 SHALL, when enqueue and pop occur on the same edge, keep count unchanged and advance both pointers.
REQ-019 SHALL, when full, deassert in_ready even if a pop occurs in the same cycle; the freed slot is usable from the next cycle.
REQ-020 SHALL, on flush, zero count, head and tail at the next edge; flush overrides any concurrent enqueue and pop.
REQ-021 SHALL force rf_wen low in a cycle where flush is high.
REQ-022 SHALL, while empty, drive rf_waddr and rf_wdata to 0.
REQ-023 SHALL drive bypass output k as follows: byp_hitk = 1 when any occupied entry has waddr == byp_raddrk; byp_datak is the wdata of the youngest matching entry, and 0 on a miss.
REQ-024 SHALL make the bypass lookup combinational over registered entries only; an entry enqueued at edge N becomes visible after edge N.
REQ-025 SHALL never report a bypass hit for byp_raddrk == 0.
REQ-026 SHALL not treat an in_valid that is asserted while in_ready is low as a request; in_waddr and in_wdata are don't-care in that cycle.

Reset
REQ-027 SHALL, while rst_n is low, asynchronously force count, head and tail to 0; rf_wen, byp_hit1 and byp_hit2 to 0; in_ready to 1.
REQ-028 SHALL abandon any in-flight entries on reset mid-operation, and SHALL issue no rf_wen in the first cycle after reset release.
REQ-029 SHALL not reset entry payload storage; only the occupancy state is reset.

Configuration
REQ-030 SHALL, when macro WBQ_BYPASS_EN is defined, implement REQ-023 through REQ-025.
REQ-031 SHALL, when WBQ_BYPASS_EN is undefined, tie byp_hit1, byp_hit2, byp_data1 and byp_data2 to 0 and synthesize no comparators; all other behaviour is identical.

Structure
REQ-032 SHALL take DATA_WIDTH and ADDR_WIDTH defaults, plus the entry struct {waddr, wdata}, from the shared package cpu_pkg.
REQ-033 SHALL factor the youngest-match search into one sub-module, wbq_match, instantiated once per lookup port.

Verification
REQ-034 Bench SHALL cover: reset, then enqueue (r3, 0x11) with rf_stall=0 -> rf_wen=1, rf_waddr=3, rf_wdata=0x11 in the next cycle; count returns to 0.
REQ-035 Bench SHALL cover: hold rf_stall=1 and enqueue 4 writes -> count=4 and in_ready=0; a 5th in_valid is not accepted; release rf_stall -> 4 writes drain in order on consecutive cycles.
REQ-036 Bench SHALL cover: enqueue (r0, 0xFF) -> handshake completes, count=0, rf_wen is never asserted.
REQ-037 Bench SHALL cover: rf_stall=1, enqueue (r5, 0xA) then (r5, 0xB); byp_raddr1=5 -> byp_hit1=1, byp_data1=0xB; byp_raddr2=6 -> byp_hit2=0, byp_data2=0.
REQ-038 Bench SHALL cover: queue holds 3 entries, then assert flush together with in_valid -> count=0 next cycle, no rf_wen, the new request is not stored.
REQ-039 Bench SHALL cover: rst_n pulsed low mid-drain with 2 entries -> rf_wen drops immediately, count=0, and there are no writes after release.
